// File: rtl/vai_mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module   : vai_mmio_initiator
// Purpose  : cmd/rsp -> CCI-P c0 MMIO requester with c2 tid matching, read
//            timeout and stray-response counting. VAI_MMIO_INIT_LATMAX_EN
//            enables max matched-read latency tracking on lat_max_o.
// Revision : 1.0  initial release
// ============================================================================
module vai_mmio_initiator #(
    parameter int TID_WIDTH      = 9,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int WR_SETTLE      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [63:0]           cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [63:0]           rsp_data_o,
    output logic                  rsp_timeout_o,
    output logic                  rsp_err_o,
    output logic                  mmio_wr_valid_o,
    output logic                  mmio_rd_valid_o,
    output logic [ADDR_WIDTH-1:0] mmio_addr_o,
    output logic [1:0]            mmio_length_o,
    output logic [TID_WIDTH-1:0]  mmio_tid_o,
    output logic [63:0]           mmio_data_o,
    input  logic                  c2_rd_valid_i,
    input  logic [TID_WIDTH-1:0]  c2_tid_i,
    input  logic [63:0]           c2_data_i,
    output logic [15:0]           stray_cnt_o,
    output logic [15:0]           lat_max_o
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SET_W = (WR_SETTLE > 1) ? $clog2(WR_SETTLE) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(WR_SETTLE - 1);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [TID_WIDTH-1:0]  tid_q, tid_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [SET_W-1:0]      settle_q, settle_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]           wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [63:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [15:0]           stray_q, stray_d;

    logic w_cmd_ready;
    logic w_issue;
    logic w_match;
    logic w_stray;

    // The completion pulse lands while the FSM is already back in IDLE, so
    // it must also hold off the next command for that cycle.
    assign w_cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q;
    assign w_issue     = (state_q == ST_ISSUE);
    assign w_match     = c2_rd_valid_i && (state_q == ST_WAIT) && (c2_tid_i == tid_q);
    assign w_stray     = c2_rd_valid_i && !w_match;

    always_comb begin
        state_d       = state_q;
        tid_d         = tid_q;
        timer_d       = timer_q;
        settle_d      = settle_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = 64'd0;
        rsp_timeout_d = 1'b0;
        rsp_err_d     = 1'b0;
        stray_d       = stray_q;

        if (w_stray && (stray_q != 16'hFFFF)) begin
            stray_d = stray_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && w_cmd_ready) begin
                    if (cmd_addr_i[0]) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        write_d = cmd_write_i;
                        addr_d  = cmd_addr_i;
                        wdata_d = cmd_wdata_i;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (write_q) begin
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    timer_d = TMR_ONE;
                    state_d = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    settle_d = settle_q + SET_ONE;
                end
            end
            ST_WAIT: begin
                // A match on the expiry cycle is still a good completion.
                if (w_match) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = c2_data_i;
                    tid_d       = tid_q + TID_WIDTH'(1);
                    timer_d     = '0;
                    state_d     = ST_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = 64'hFFFF_FFFF_FFFF_FFFF;
                    tid_d         = tid_q + TID_WIDTH'(1);
                    timer_d       = '0;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tid_q         <= '0;
            timer_q       <= '0;
            settle_q      <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= 64'd0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 64'd0;
            rsp_timeout_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            stray_q       <= 16'd0;
        end else begin
            state_q       <= state_d;
            tid_q         <= tid_d;
            timer_q       <= timer_d;
            settle_q      <= settle_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_err_q     <= rsp_err_d;
            stray_q       <= stray_d;
        end
    end

`ifdef VAI_MMIO_INIT_LATMAX_EN
    logic [15:0] lat_max_q;
    logic [31:0] w_lat32;
    logic [15:0] w_lat16;

    // timer_q equals cycles elapsed since the issue cycle while waiting.
    assign w_lat32 = 32'(timer_q);
    assign w_lat16 = (w_lat32 > 32'h0000_FFFF) ? 16'hFFFF : w_lat32[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_max_q <= 16'd0;
        end else if (w_match && (w_lat16 > lat_max_q)) begin
            lat_max_q <= w_lat16;
        end
    end

    assign lat_max_o = lat_max_q;
`else
    assign lat_max_o = 16'd0;
`endif

    assign cmd_ready_o     = w_cmd_ready;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_timeout_o   = rsp_timeout_q;
    assign rsp_err_o       = rsp_err_q;
    assign mmio_wr_valid_o = w_issue && write_q;
    assign mmio_rd_valid_o = w_issue && !write_q;
    assign mmio_addr_o     = w_issue ? addr_q : '0;
    assign mmio_length_o   = 2'b01;
    assign mmio_tid_o      = (w_issue && !write_q) ? tid_q : '0;
    assign mmio_data_o     = (w_issue && write_q) ? wdata_q : 64'd0;
    assign stray_cnt_o     = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_vai_mmio_initiator.sv
`default_nettype none
// Directed bench for vai_mmio_initiator with a small CSR responder model
// (configurable response delay, silence, and injected c2 responses).
module tb_vai_mmio_initiator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        rsp_valid, rsp_timeout, rsp_err;
    logic [63:0] rsp_data;
    logic        mmio_wr_valid, mmio_rd_valid;
    logic [15:0] mmio_addr;
    logic [1:0]  mmio_length;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_data;
    logic        c2_rd_valid;
    logic [8:0]  c2_tid;
    logic [63:0] c2_data;
    logic [15:0] stray_cnt, lat_max;

    vai_mmio_initiator #(
        .TID_WIDTH(9), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(16), .WR_SETTLE(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .rsp_timeout_o(rsp_timeout), .rsp_err_o(rsp_err),
        .mmio_wr_valid_o(mmio_wr_valid), .mmio_rd_valid_o(mmio_rd_valid),
        .mmio_addr_o(mmio_addr), .mmio_length_o(mmio_length),
        .mmio_tid_o(mmio_tid), .mmio_data_o(mmio_data),
        .c2_rd_valid_i(c2_rd_valid), .c2_tid_i(c2_tid), .c2_data_i(c2_data),
        .stray_cnt_o(stray_cnt), .lat_max_o(lat_max)
    );

    // ---------------- responder model ----------------
    logic        resp_en;
    int          resp_delay;
    logic        inj_valid;
    logic [8:0]  inj_tid;
    logic        pend;
    int          age;
    logic [8:0]  p_tid;
    logic [63:0] p_data;
    logic [63:0] sub_afu_reset;

    function automatic logic [63:0] csr_val(input logic [15:0] a, input logic [63:0] sar);
        case (a)
            16'h0002: csr_val = 64'ha0a013a421139e69;
            16'h0004: csr_val = 64'hd1d383aaca4c4c60;
            16'h0006: csr_val = sar;
            16'h0008: csr_val = 64'd8;
            default:  csr_val = 64'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
            age <= 0;
            sub_afu_reset <= 64'd0;
        end else begin
            if (mmio_wr_valid && mmio_addr == 16'h0006)
                sub_afu_reset <= mmio_data & 64'hFF;
            if (mmio_rd_valid && resp_en) begin
                pend   <= 1'b1;
                age    <= 1;
                p_tid  <= mmio_tid;
                p_data <= csr_val(mmio_addr, sub_afu_reset);
            end else if (pend) begin
                if (age == resp_delay) pend <= 1'b0;
                else age <= age + 1;
            end
        end
    end

    assign c2_rd_valid = inj_valid | (pend && (age == resp_delay));
    assign c2_tid      = inj_valid ? inj_tid : p_tid;
    assign c2_data     = inj_valid ? 64'hDEAD_BEEF_0000_0001 : p_data;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int exp_stray = 0;

    logic        r_got, r_tout, r_err, r_rdy;
    int          r_k, r_rdp, r_wrp;
    logic [63:0] r_data, r_pdata;
    logic [15:0] r_paddr;
    logic [8:0]  r_ptid;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; cmd_valid = 1'b0; inj_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_stray = 0;
    endtask

    // Issues one command and collects what happens until the completion pulse.
    // r_k counts cycles after the accept cycle (1 == issue cycle).
    task automatic do_cmd(input logic w, input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'd0; cmd_wdata = 64'd0;
        r_got = 0; r_k = 1; r_rdp = 0; r_wrp = 0; r_rdy = 0; r_tout = 0; r_err = 0;
        r_data = 0; r_pdata = 0; r_paddr = 0; r_ptid = 0;
        while (!r_got && r_k < 100) begin
            if (mmio_rd_valid || mmio_wr_valid) begin
                if (mmio_rd_valid) r_rdp++;
                if (mmio_wr_valid) r_wrp++;
                r_ptid = mmio_tid; r_paddr = mmio_addr; r_pdata = mmio_data;
            end
            if (cmd_ready) r_rdy = 1;
            if (rsp_valid) begin
                r_got = 1; r_data = rsp_data; r_tout = rsp_timeout; r_err = rsp_err;
            end else begin
                @(negedge clk);
                r_k++;
            end
        end
    endtask

    task automatic inject(input logic [8:0] t);
        @(negedge clk);
        inj_valid = 1'b1; inj_tid = t;
        @(negedge clk);
        inj_valid = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_timeout, rsp_err, mmio_wr_valid, mmio_rd_valid} !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {cmd_ready, rsp_valid, rsp_timeout, rsp_err, mmio_wr_valid, mmio_rd_valid});
        end
        n_cmp++;
        if ({stray_cnt, lat_max, mmio_addr, mmio_tid} !== 57'd0 || rsp_data !== 64'd0 || mmio_data !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_data: stray %h lat %h addr %h tid %h rdata %h mdata %h expected all 0",
                     stray_cnt, lat_max, mmio_addr, mmio_tid, rsp_data, mmio_data);
        end
        n_cmp++;
        if (mmio_length !== 2'b01) begin
            n_bad++; $display("FAIL length: got %b expected 01", mmio_length);
        end
    endtask

    task automatic test_write_read();
        do_cmd(1'b1, 16'h6, 64'h5);
        n_cmp++;
        if ({r_got, r_err, r_tout, r_rdy} !== 4'b1000 || r_k !== 6 || r_data !== 64'd0) begin
            n_bad++;
            $display("FAIL write_done: got/err/tout/rdy %b k %0d data %h expected 1000 k 6 data 0",
                     {r_got, r_err, r_tout, r_rdy}, r_k, r_data);
        end
        n_cmp++;
        if (r_wrp !== 1 || r_rdp !== 0 || r_paddr !== 16'h6 || r_pdata !== 64'h5 || r_ptid !== 9'd0) begin
            n_bad++;
            $display("FAIL write_pulse: wr %0d rd %0d addr %h data %h tid %0d expected 1 0 6 5 0",
                     r_wrp, r_rdp, r_paddr, r_pdata, r_ptid);
        end
        n_cmp++;
        if (sub_afu_reset !== 64'h5) begin
            n_bad++; $display("FAIL sub_afu_reset: got %h expected 5", sub_afu_reset);
        end
        do_cmd(1'b0, 16'h6, 64'h0);
        n_cmp++;
        if ({r_got, r_tout, r_err} !== 3'b100 || r_data !== 64'h5 || r_k !== 5) begin
            n_bad++;
            $display("FAIL read_back: got/tout/err %b data %h k %0d expected 100 5 k 5",
                     {r_got, r_tout, r_err}, r_data, r_k);
        end
        n_cmp++;
        if (r_rdp !== 1 || r_wrp !== 0 || r_pdata !== 64'd0 || r_ptid !== 9'd0) begin
            n_bad++;
            $display("FAIL read_pulse: rd %0d wr %0d data %h tid %0d expected 1 0 0 0", r_rdp, r_wrp, r_pdata, r_ptid);
        end
    endtask

    task automatic test_reads();
        logic [15:0] addrs [3];
        logic [63:0] exps  [3];
        addrs = '{16'h8, 16'h2, 16'h4};
        exps  = '{64'd8, 64'ha0a013a421139e69, 64'hd1d383aaca4c4c60};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_cmd(1'b0, addrs[i], 64'd0);
            n_cmp++;
            if (r_got !== 1'b1 || r_tout !== 1'b0 || r_data !== exps[i] || r_ptid !== 9'(i) || r_paddr !== addrs[i]) begin
                n_bad++;
                $display("FAIL read_%0d: got %b tout %b data %h tid %0d addr %h expected 1 0 %h %0d %h",
                         i, r_got, r_tout, r_data, r_ptid, r_paddr, exps[i], i, addrs[i]);
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        resp_en = 1'b0;
        do_cmd(1'b0, 16'h8, 64'd0);
        resp_en = 1'b1;
        n_cmp++;
        if ({r_got, r_tout, r_err} !== 3'b110 || r_k !== 18 || r_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++;
            $display("FAIL timeout: got/tout/err %b k %0d data %h expected 110 k 18 all-ones",
                     {r_got, r_tout, r_err}, r_k, r_data);
        end
        inject(9'd0);
        exp_stray++;
        n_cmp++;
        if (stray_cnt !== 16'(exp_stray)) begin
            n_bad++; $display("FAIL late_stray: got %0d expected %0d", stray_cnt, exp_stray);
        end
        do_cmd(1'b0, 16'h8, 64'd0);
        n_cmp++;
        if (r_ptid !== 9'd1 || r_data !== 64'd8 || r_tout !== 1'b0) begin
            n_bad++; $display("FAIL tid_after_timeout: tid %0d data %h tout %b expected 1 8 0", r_ptid, r_data, r_tout);
        end
    endtask

    task automatic test_err();
        do_cmd(1'b0, 16'h7, 64'd0);
        n_cmp++;
        if ({r_got, r_err, r_tout} !== 3'b110 || r_k !== 1 || r_data !== 64'd0 || r_rdp !== 0 || r_wrp !== 0) begin
            n_bad++;
            $display("FAIL misaligned: got/err/tout %b k %0d data %h rd %0d wr %0d expected 110 k 1 0 0 0",
                     {r_got, r_err, r_tout}, r_k, r_data, r_rdp, r_wrp);
        end
        inject(9'd5);
        exp_stray++;
        n_cmp++;
        if (stray_cnt !== 16'(exp_stray)) begin
            n_bad++; $display("FAIL idle_stray: got %0d expected %0d", stray_cnt, exp_stray);
        end
    endtask

    task automatic test_expiry_edge();
        resp_delay = 16;
        do_cmd(1'b0, 16'h8, 64'd0);
        n_cmp++;
        if (r_got !== 1'b1 || r_tout !== 1'b0 || r_data !== 64'd8 || r_k !== 18) begin
            n_bad++;
            $display("FAIL match_wins: got %b tout %b data %h k %0d expected 1 0 8 18", r_got, r_tout, r_data, r_k);
        end
        resp_delay = 17;
        do_cmd(1'b0, 16'h8, 64'd0);
        @(negedge clk);
        exp_stray++;
        n_cmp++;
        if (r_tout !== 1'b1 || r_k !== 18 || stray_cnt !== 16'(exp_stray)) begin
            n_bad++;
            $display("FAIL one_late: tout %b k %0d stray %0d expected 1 18 %0d", r_tout, r_k, stray_cnt, exp_stray);
        end
        resp_delay = 3;
    endtask

    task automatic test_back_to_back();
        int          bad;
        logic [15:0] a;
        logic [63:0] e;
        logic [8:0]  t511, t512;
        apply_reset();
        resp_delay = 1;
        bad = 0; t511 = 0; t512 = 1;
        for (int i = 0; i < 520; i++) begin
            a = (i % 3 == 0) ? 16'h8 : ((i % 3 == 1) ? 16'h2 : 16'h4);
            e = (i % 3 == 0) ? 64'd8 : ((i % 3 == 1) ? 64'ha0a013a421139e69 : 64'hd1d383aaca4c4c60);
            do_cmd(1'b0, a, 64'd0);
            if (!r_got || r_tout || r_data !== e || r_ptid !== 9'(i) || r_k !== 3) bad++;
            if (i == 511) t511 = r_ptid;
            if (i == 512) t512 = r_ptid;
        end
        resp_delay = 3;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL b2b_reads: %0d bad responses expected 0", bad);
        end
        n_cmp++;
        if (t511 !== 9'd511 || t512 !== 9'd0) begin
            n_bad++; $display("FAIL tid_wrap: got %0d,%0d expected 511,0", t511, t512);
        end
        n_cmp++;
        if (stray_cnt !== 16'd0) begin
            n_bad++; $display("FAIL b2b_stray: got %0d expected 0", stray_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        int seen;
        resp_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h8; cmd_wdata = 64'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_stray = 0;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_wait: rsp pulses %0d ready %b expected 0 1", seen, cmd_ready);
        end
        resp_en = 1'b1;
        do_cmd(1'b0, 16'h8, 64'd0);
        n_cmp++;
        if (r_ptid !== 9'd0 || r_data !== 64'd8) begin
            n_bad++; $display("FAIL tid_after_reset: tid %0d data %h expected 0 8", r_ptid, r_data);
        end
    endtask

    task automatic test_latmax();
        int exp3, exp9;
`ifdef VAI_MMIO_INIT_LATMAX_EN
        exp3 = 3; exp9 = 9;
`else
        exp3 = 0; exp9 = 0;
`endif
        apply_reset();
        resp_delay = 3;
        do_cmd(1'b0, 16'h8, 64'd0);
        n_cmp++;
        if (lat_max !== 16'(exp3)) begin
            n_bad++; $display("FAIL lat_3: got %0d expected %0d", lat_max, exp3);
        end
        resp_delay = 9;
        do_cmd(1'b0, 16'h8, 64'd0);
        resp_delay = 5;
        do_cmd(1'b0, 16'h8, 64'd0);
        n_cmp++;
        if (lat_max !== 16'(exp9)) begin
            n_bad++; $display("FAIL lat_9: got %0d expected %0d", lat_max, exp9);
        end
        resp_en = 1'b0;
        do_cmd(1'b0, 16'h8, 64'd0);
        resp_en = 1'b1;
        resp_delay = 3;
        n_cmp++;
        if (lat_max !== 16'(exp9) || r_tout !== 1'b1) begin
            n_bad++; $display("FAIL lat_timeout_excluded: got %0d tout %b expected %0d 1", lat_max, r_tout, exp9);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'd0; cmd_wdata = 64'd0;
        resp_en = 1'b1; resp_delay = 3; inj_valid = 1'b0; inj_tid = 9'd0;
        test_reset();
        test_write_read();
        test_reads();
        test_timeout();
        test_err();
        test_expiry_edge();
        test_back_to_back();
        test_reset_in_wait();
        test_latmax();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
